vga_framebuffer_40x30: RTL and testbench
========================================

Name: vga_framebuffer_40x30

Overview:
Character-cell framebuffer that sits directly upstream of the VGA driver. It takes the driver's ROW/COLUMN pixel coordinates, maps them onto a 40x30 grid of 16x16-pixel cells, and returns 8-bit RGB (3/3/2) to the driver's RED/GREEN/BLUE inputs. On the MCU side it provides a write port, a registered readback port, and a hardware clear-screen engine. Everything runs in the single 25 MHz pixel-clock domain.

Parameters:
COLS, 40, cells per row; valid cell column 0..COLS-1
ROWS, 30, cell rows; valid cell row 0..ROWS-1
CELL_SHIFT, 4, log2 of cell size in pixels (16x16)

Ports:
CLK        input   1   pixel clock, 25 MHz
RST_N      input   1   asynchronous active-low reset
ROW        input   10  pixel row from driver, 0..524
COLUMN     input   10  pixel column from driver, 0..799
RED        output  3   pixel red to driver
GREEN      output  3   pixel green to driver
BLUE       output  2   pixel blue to driver
WE         input   1   MCU write strobe, one write per cycle high
WA         input   11  MCU cell address {row[4:0], col[5:0]}
WD         input   8   MCU write data {R[2:0], G[2:0], B[1:0]}
RD         output  8   MCU readback of cell at WA
CLR        input   1   start clear-screen, sampled when high
CLR_COLOR  input   8   fill colour, latched on accepted CLR
BUSY       output  1   clear engine active

Behaviour:
- Storage: 2048x8 memory, address {cell_row[4:0], cell_col[5:0]}. Only cells with col<COLS and row<ROWS are used. Contents are not reset and power up as 0.
- Pixel path: cell_col = COLUMN[9:CELL_SHIFT], cell_row = ROW[8:CELL_SHIFT]. Read latency is 1 cycle. RED/GREEN/BLUE are registered and equal mem[addr][7:5]/[4:2]/[1:0] for the ROW/COLUMN sampled on the previous edge.
- If the sampled COLUMN>=640 or ROW>=480, the next-cycle RGB is 0.
- Reset (RST_N low, async): RED/GREEN/BLUE=0, RD=0, BUSY=0, FSM goes to IDLE, counters=0. Reset during a clear aborts it; partially cleared memory stays as it is.
- MCU write: WE high at a rising edge while FSM is IDLE and CLR is low writes WD into mem[WA]. The write is dropped if WA col field >=COLS or row field >=ROWS.
- RD: registered, 1-cycle latency, RD = mem[WA sampled previous edge]. Out-of-range WA returns 0.
- Read-during-write on the same address returns old data on both RD and the pixel path (read-first).
- Clear FSM:
  - IDLE: CLR high latches CLR_COLOR, zeroes the row and column counters, and moves to FILL. If WE is high in the same cycle, the write is dropped (CLR has priority).
  - FILL: each cycle writes the latched colour to {row_cnt, col_cnt}, then increments col_cnt. At col_cnt=COLS-1 it wraps to 0 and increments row_cnt. The write at (ROWS-1, COLS-1) is the final one; the FSM then returns to IDLE.
- BUSY is 1 in every FILL cycle: exactly COLS*ROWS = 1200 cycles, asserted the cycle after CLR is accepted.
- While BUSY: WE is ignored (dropped, not queued), CLR is ignored (no restart), and the pixel path and RD keep reading live memory, so partial fills are visible.
- No combinational path from any input to any output.

Test Plan:
- Reset, then hold ROW=0, COLUMN=0 -> RED/GREEN/BLUE=0, BUSY=0, RD=0; assert RST_N low mid-frame -> outputs 0 immediately, without waiting for a clock edge.
- Write WA={5'd2,6'd3}, WD=8'hE5; then drive ROW=32..47, COLUMN=48..63 -> one cycle later RED=7, GREEN=1, BLUE=1. COLUMN=64 on the same row -> that cell's old value (0).
- Write WA={5'd0,6'd40}, WD=8'hFF (col out of range); then read WA={0,40} -> RD=0 and no pixel change. Drive COLUMN=700 -> RGB=0.
- CLR with CLR_COLOR=8'h1C -> BUSY high for exactly 1200 cycles. Afterwards RD=8'h1C at WA={0,0} and at {29,39}; pixel at ROW=479, COLUMN=639 gives GREEN=7, RED=0, BLUE=0.
- During a clear, WE to {1,1} with WD=8'hAA and a second CLR pulse -> both ignored: after BUSY falls, cell {1,1}=fill colour and BUSY length is still 1200. CLR and WE in the same idle cycle -> write dropped.
- Assert RST_N low after 500 FILL cycles -> BUSY=0 at once. Cells 0..499 in scan order hold the fill colour; remaining cells keep their prior values.

Source files
------------

// File: rtl/vga_framebuffer_40x30_if.sv
// MCU-side bus of the 40x30 character-cell framebuffer: cell write/readback and clear engine.
`timescale 1ns / 1ps
interface vga_framebuffer_40x30_if;
  logic        WE;
  logic [10:0] WA;
  logic [7:0]  WD;
  logic [7:0]  RD;
  logic        CLR;
  logic [7:0]  CLR_COLOR;
  logic        BUSY;

  modport master (output WE, WA, WD, CLR, CLR_COLOR, input RD, BUSY);
  modport slave  (input WE, WA, WD, CLR, CLR_COLOR, output RD, BUSY);
endinterface

// File: rtl/vga_framebuffer_40x30.sv
// 40x30 grid of 16x16-pixel cells feeding RGB332 to the VGA driver, with an MCU write port,
// registered readback and a hardware clear-screen engine. Single pixel-clock domain.
`timescale 1ns / 1ps
module vga_framebuffer_40x30 #(
  parameter int unsigned COLS       = 40,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned CELL_SHIFT = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [9:0]                    ROW,
  input  logic [9:0]                    COLUMN,
  output logic [2:0]                    RED,
  output logic [2:0]                    GREEN,
  output logic [1:0]                    BLUE,
  vga_framebuffer_40x30_if.slave        mcu
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StFill = 1'b1;

  logic [7:0]  mem [2048];

  logic [0:0]  state_q, state_d;
  logic [4:0]  row_cnt_q, row_cnt_d;
  logic [5:0]  col_cnt_q, col_cnt_d;
  logic [7:0]  color_q, color_d;
  logic [7:0]  rgb_q, rgb_d;
  logic [7:0]  rd_q, rd_d;

  logic [5:0]  pix_col;
  logic [4:0]  pix_row;
  logic        pix_vis;
  logic        wa_valid;
  logic        mem_we;
  logic [10:0] mem_waddr;
  logic [7:0]  mem_wdata;

  // Reads see the array before this edge's write lands, giving read-first behaviour.
  always_comb begin
    pix_col  = 6'(COLUMN >> CELL_SHIFT);
    pix_row  = 5'(ROW >> CELL_SHIFT);
    pix_vis  = (COLUMN < 10'(COLS << CELL_SHIFT)) && (ROW < 10'(ROWS << CELL_SHIFT));
    wa_valid = (32'(mcu.WA[5:0]) < COLS) && (32'(mcu.WA[10:6]) < ROWS);
    rgb_d    = pix_vis ? mem[{pix_row, pix_col}] : 8'h00;
    rd_d     = wa_valid ? mem[mcu.WA] : 8'h00;
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    color_d   = color_q;
    mem_we    = 1'b0;
    mem_waddr = mcu.WA;
    mem_wdata = mcu.WD;
    case (state_q)
      StIdle: begin
        // CLR wins over a simultaneous write.
        if (mcu.CLR) begin
          state_d   = StFill;
          color_d   = mcu.CLR_COLOR;
          row_cnt_d = '0;
          col_cnt_d = '0;
        end else if (mcu.WE && wa_valid) begin
          mem_we = 1'b1;
        end
      end
      StFill: begin
        mem_we    = 1'b1;
        mem_waddr = {row_cnt_q, col_cnt_q};
        mem_wdata = color_q;
        if (32'(col_cnt_q) == COLS - 1) begin
          col_cnt_d = '0;
          if (32'(row_cnt_q) == ROWS - 1) begin
            row_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            row_cnt_d = row_cnt_q + 5'd1;
          end
        end else begin
          col_cnt_d = col_cnt_q + 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      color_q   <= '0;
      rgb_q     <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      color_q   <= color_d;
      rgb_q     <= rgb_d;
      rd_q      <= rd_d;
    end
  end

  // Cell storage is deliberately not reset so an aborted clear leaves its partial fill.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign RED      = rgb_q[7:5];
  assign GREEN    = rgb_q[4:2];
  assign BLUE     = rgb_q[1:0];
  assign mcu.RD   = rd_q;
  assign mcu.BUSY = (state_q == StFill);

endmodule

// File: tb/tb_vga_framebuffer_40x30.sv
// Self-checking bench for vga_framebuffer_40x30: randomized traffic against a cell-array model.
`timescale 1ns / 1ps
module tb_vga_framebuffer_40x30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] row = '0;
  logic [9:0] column = '0;
  logic [2:0] red, green;
  logic [1:0] blue;

  vga_framebuffer_40x30_if mcu ();

  vga_framebuffer_40x30 dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .ROW    (row),
    .COLUMN (column),
    .RED    (red),
    .GREEN  (green),
    .BLUE   (blue),
    .mcu    (mcu)
  );

  always #20 clk = ~clk;

  logic [7:0] model [30][40];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [7:0] exp_pix(input logic [9:0] r, input logic [9:0] c);
    if (c >= 10'd640 || r >= 10'd480) return 8'h00;
    return model[int'(r) / 16][int'(c) / 16];
  endfunction

  function automatic logic [7:0] exp_rd(input logic [10:0] wa);
    if (wa[5:0] >= 6'd40 || wa[10:6] >= 5'd30) return 8'h00;
    return model[wa[10:6]][wa[5:0]];
  endfunction

  function automatic void model_write(input logic [10:0] wa, input logic [7:0] wd);
    if (wa[5:0] < 6'd40 && wa[10:6] < 5'd30) model[wa[10:6]][wa[5:0]] = wd;
  endfunction

  function automatic void model_fill(input logic [7:0] color, input int ncells);
    for (int i = 0; i < ncells; i++) model[i / 40][i % 40] = color;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [10:0] wa, input logic [7:0] wd);
    mcu.WE = 1'b1;
    mcu.WA = wa;
    mcu.WD = wd;
    step();
    mcu.WE = 1'b0;
    model_write(wa, wd);
  endtask

  task automatic run_clear(input logic [7:0] color, output int len);
    mcu.CLR       = 1'b1;
    mcu.CLR_COLOR = color;
    step();
    mcu.CLR = 1'b0;
    len = 0;
    while (mcu.BUSY === 1'b1 && len < 2000) begin
      len++;
      step();
    end
    model_fill(color, 1200);
  endtask

  task automatic test_reset();
    #5;
    n_cmp++;
    if ({red, green, blue} !== 8'h00) begin
      n_bad++; $display("FAIL reset_rgb: got %h expected 00", {red, green, blue});
    end
    n_cmp++;
    if (mcu.RD !== 8'h00) begin
      n_bad++; $display("FAIL reset_rd: got %h expected 00", mcu.RD);
    end
    n_cmp++;
    if (mcu.BUSY !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy: got %b expected 0", mcu.BUSY);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_init_clear();
    int len;
    run_clear(8'h00, len);
    n_cmp++;
    if (len != 1200) begin
      n_bad++; $display("FAIL init_clear_len: got %0d expected 1200", len);
    end
    row = '0; column = '0; mcu.WA = '0;
    step();
    n_cmp++;
    if ({red, green, blue} !== 8'h00 || mcu.RD !== 8'h00 || mcu.BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_outputs: got rgb=%h rd=%h busy=%b expected 00/00/0",
               {red, green, blue}, mcu.RD, mcu.BUSY);
    end
  endtask

  task automatic test_write_pixel();
    do_write({5'd2, 6'd3}, 8'hE5);
    for (int k = 0; k < 6; k++) begin
      row    = 10'(32 + $urandom_range(0, 15));
      column = 10'(48 + $urandom_range(0, 15));
      step();
      n_cmp++;
      if (red !== 3'd7 || green !== 3'd1 || blue !== 2'd1) begin
        n_bad++;
        $display("FAIL cell_pixel: got %0d/%0d/%0d expected 7/1/1", red, green, blue);
      end
    end
    column = 10'd64;
    step();
    n_cmp++;
    if ({red, green, blue} !== exp_pix(row, column)) begin
      n_bad++;
      $display("FAIL neighbour_pixel: got %h expected %h", {red, green, blue}, exp_pix(row, column));
    end
  endtask

  task automatic test_out_of_range();
    do_write({5'd0, 6'd40}, 8'hFF);
    do_write({5'd30, 6'd0}, 8'hAA);
    mcu.WA = {5'd0, 6'd40};
    row = 10'd0; column = 10'd639;
    step();
    n_cmp++;
    if (mcu.RD !== 8'h00) begin
      n_bad++; $display("FAIL oor_col_rd: got %h expected 00", mcu.RD);
    end
    n_cmp++;
    if ({red, green, blue} !== exp_pix(row, column)) begin
      n_bad++;
      $display("FAIL oor_no_pixel_change: got %h expected %h", {red, green, blue},
               exp_pix(row, column));
    end
    mcu.WA = {5'd30, 6'd0};
    row = 10'd100; column = 10'd700;
    step();
    n_cmp++;
    if (mcu.RD !== 8'h00) begin
      n_bad++; $display("FAIL oor_row_rd: got %h expected 00", mcu.RD);
    end
    n_cmp++;
    if ({red, green, blue} !== 8'h00) begin
      n_bad++; $display("FAIL blank_col700: got %h expected 00", {red, green, blue});
    end
    row = 10'd500; column = 10'd48;
    step();
    n_cmp++;
    if ({red, green, blue} !== 8'h00) begin
      n_bad++; $display("FAIL blank_row500: got %h expected 00", {red, green, blue});
    end
  endtask

  task automatic test_read_during_write();
    do_write({5'd3, 6'd5}, 8'h11);
    mcu.WE = 1'b1; mcu.WA = {5'd3, 6'd5}; mcu.WD = 8'h99;
    row = 10'd48; column = 10'd80;
    step();
    mcu.WE = 1'b0;
    model_write({5'd3, 6'd5}, 8'h99);
    n_cmp++;
    if (mcu.RD !== 8'h11 || {red, green, blue} !== 8'h11) begin
      n_bad++;
      $display("FAIL rdw_old: got rd=%h rgb=%h expected 11/11", mcu.RD, {red, green, blue});
    end
    step();
    n_cmp++;
    if (mcu.RD !== 8'h99 || {red, green, blue} !== 8'h99) begin
      n_bad++;
      $display("FAIL rdw_new: got rd=%h rgb=%h expected 99/99", mcu.RD, {red, green, blue});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] e_pix, e_rd;
      logic [4:0] wr;
      logic [5:0] wc;
      wr = 5'($urandom_range(0, 31));
      wc = 6'($urandom_range(0, 44));
      mcu.WE = 1'($urandom_range(0, 1));
      mcu.WA = {wr, wc};
      mcu.WD = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        row    = 10'(int'(wr) * 16 + $urandom_range(0, 15));
        column = 10'(int'(wc) * 16 + $urandom_range(0, 15));
      end else begin
        row    = 10'($urandom_range(0, 524));
        column = 10'($urandom_range(0, 799));
      end
      e_pix = exp_pix(row, column);
      e_rd  = exp_rd(mcu.WA);
      if (mcu.WE) model_write(mcu.WA, mcu.WD);
      step();
      n_cmp++;
      if ({red, green, blue} !== e_pix) begin
        n_bad++;
        $display("FAIL rand_pixel[%0d]: got %h expected %h", i, {red, green, blue}, e_pix);
      end
      n_cmp++;
      if (mcu.RD !== e_rd) begin
        n_bad++; $display("FAIL rand_rd[%0d]: got %h expected %h", i, mcu.RD, e_rd);
      end
    end
    mcu.WE = 1'b0;
  endtask

  task automatic test_clear();
    int len;
    run_clear(8'h1C, len);
    n_cmp++;
    if (len != 1200) begin
      n_bad++; $display("FAIL clear_busy_len: got %0d expected 1200", len);
    end
    mcu.WA = {5'd0, 6'd0};
    step();
    n_cmp++;
    if (mcu.RD !== 8'h1C) begin
      n_bad++; $display("FAIL clear_first_cell: got %h expected 1c", mcu.RD);
    end
    mcu.WA = {5'd29, 6'd39};
    row = 10'd479; column = 10'd639;
    step();
    n_cmp++;
    if (mcu.RD !== 8'h1C) begin
      n_bad++; $display("FAIL clear_last_cell: got %h expected 1c", mcu.RD);
    end
    n_cmp++;
    if (red !== 3'd0 || green !== 3'd7 || blue !== 2'd0) begin
      n_bad++; $display("FAIL clear_pixel: got %0d/%0d/%0d expected 0/7/0", red, green, blue);
    end
  endtask

  task automatic test_clear_ignore();
    int len;
    mcu.CLR = 1'b1; mcu.CLR_COLOR = 8'h3A;
    step();
    mcu.CLR = 1'b0;
    len = 0;
    while (mcu.BUSY === 1'b1 && len < 2000) begin
      len++;
      if (len == 300) begin
        mcu.WE = 1'b1; mcu.WA = {5'd1, 6'd1}; mcu.WD = 8'hAA;
        mcu.CLR = 1'b1; mcu.CLR_COLOR = 8'h55;
      end else begin
        mcu.WE = 1'b0; mcu.CLR = 1'b0;
      end
      step();
    end
    mcu.WE = 1'b0; mcu.CLR = 1'b0;
    model_fill(8'h3A, 1200);
    n_cmp++;
    if (len != 1200) begin
      n_bad++; $display("FAIL ignore_busy_len: got %0d expected 1200", len);
    end
    mcu.WA = {5'd1, 6'd1};
    step();
    n_cmp++;
    if (mcu.RD !== 8'h3A) begin
      n_bad++; $display("FAIL ignore_we_cell: got %h expected 3a", mcu.RD);
    end
    n_cmp++;
    if (mcu.BUSY !== 1'b0) begin
      n_bad++; $display("FAIL ignore_no_restart: got %b expected 0", mcu.BUSY);
    end
  endtask

  task automatic test_clr_we_abort();
    for (int i = 0; i < 1200; i++) do_write({5'(i / 40), 6'(i % 40)}, 8'($urandom));
    mcu.CLR = 1'b1; mcu.CLR_COLOR = 8'hC3;
    mcu.WE = 1'b1; mcu.WA = {5'd29, 6'd39}; mcu.WD = ~model[29][39];
    step();
    mcu.CLR = 1'b0; mcu.WE = 1'b0;
    row = '0; column = '0;
    repeat (500) step();
    model_fill(8'hC3, 500);
    n_cmp++;
    if ({red, green, blue} !== 8'hC3 || mcu.BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL partial_fill_live: got rgb=%h busy=%b expected c3/1",
               {red, green, blue}, mcu.BUSY);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mcu.BUSY !== 1'b0 || {red, green, blue} !== 8'h00 || mcu.RD !== 8'h00) begin
      n_bad++;
      $display("FAIL async_abort: got busy=%b rgb=%h rd=%h expected 0/00/00",
               mcu.BUSY, {red, green, blue}, mcu.RD);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      mcu.WA = {5'(i / 40), 6'(i % 40)};
      step();
      n_cmp++;
      if (mcu.RD !== model[i / 40][i % 40]) begin
        n_bad++;
        $display("FAIL abort_cell[%0d]: got %h expected %h", i, mcu.RD, model[i / 40][i % 40]);
      end
    end
  endtask

  initial begin
    mcu.WE = 1'b0; mcu.WA = '0; mcu.WD = '0; mcu.CLR = 1'b0; mcu.CLR_COLOR = '0;
    for (int r = 0; r < 30; r++) for (int c = 0; c < 40; c++) model[r][c] = 8'h00;
    test_reset();
    test_init_clear();
    test_write_pixel();
    test_out_of_range();
    test_read_during_write();
    test_random();
    test_clear();
    test_clear_ignore();
    test_clr_we_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
